// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache for the core fetch port.
// A hit returns its word in the same cycle. A miss refills a 4-word block
// from main memory over a request/busywait handshake and stalls the core.
module instruction_cache #(
  parameter int unsigned INDEX_BITS = 3,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [29:0]  address_i,
  output logic [31:0]  data_o,
  output logic         blocking_n_o,
  input  logic         invalidate_i,
  output logic         mem_read_o,
  output logic [27:0]  mem_address_o,
  input  logic [127:0] mem_readdata_i,
  input  logic         mem_busywait_i
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [127:0]          data_mem [LINES];
  logic [27:0]           miss_addr;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  hit;
  logic                  refill_done;

  assign offset      = address_i[1:0];
  assign index       = address_i[INDEX_BITS+1:2];
  assign tag         = address_i[29:INDEX_BITS+2];
  assign miss_index  = miss_addr[INDEX_BITS-1:0];
  assign miss_tag    = miss_addr[27:INDEX_BITS];

  assign hit         = (state == IDLE) && valid[index] &&
                       (tag_mem[index] == tag) && !invalidate_i;
  assign refill_done = (state == MEM_READ) && !mem_busywait_i;

  assign mem_address_o = miss_addr;

  // Hit path: word select straight from the line; NOP whenever stalled.
  always_comb begin
    blocking_n_o = 1'b0;
    data_o       = NOP_WORD;
    if (hit) begin
      blocking_n_o = 1'b1;
      data_o       = data_mem[index][{offset, 5'b00000} +: 32];
    end
  end

  // Control FSM: valid bits, miss address and the memory request.
  // mem_read_o is a register so the asynchronous reset drops it at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      valid      <= '0;
      miss_addr  <= '0;
      mem_read_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (invalidate_i) begin
            valid <= '0;
          end else if (!hit) begin
            miss_addr  <= address_i[29:2];
            mem_read_o <= 1'b1;
            state      <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!mem_busywait_i) begin
            valid[miss_index] <= 1'b1;
            mem_read_o        <= 1'b0;
            state             <= UPDATE;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          mem_read_o <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: tag and data are written only when a refill completes.
  always_ff @(posedge clk_i) begin
    if (refill_done) begin
      data_mem[miss_index] <= mem_readdata_i;
      tag_mem[miss_index]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios followed by
// random fetch/invalidate traffic checked against a line-level cache model.
module tb_instruction_cache;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [29:0]  address_i = '0;
  logic [31:0]  data_o;
  logic         blocking_n_o;
  logic         invalidate_i = 1'b0;
  logic         mem_read_o;
  logic [27:0]  mem_address_o;
  logic [127:0] mem_readdata_i;
  logic         mem_busywait_i = 1'b0;

  int total = 0;
  int bad   = 0;
  int mem_lat = 1;
  int rd_cnt  = 0;
  logic [31:0] seed;

  // Reference model: per-index valid flag and tag.
  bit          ref_valid [8];
  logic [24:0] ref_tag   [8];

  instruction_cache #(
    .INDEX_BITS(3),
    .NOP_WORD  (32'h0000_0013)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .address_i     (address_i),
    .data_o        (data_o),
    .blocking_n_o  (blocking_n_o),
    .invalidate_i  (invalidate_i),
    .mem_read_o    (mem_read_o),
    .mem_address_o (mem_address_o),
    .mem_readdata_i(mem_readdata_i),
    .mem_busywait_i(mem_busywait_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] w);
    logic [31:0] byte_addr;
    byte_addr = {blk, w, 2'b00};
    return (byte_addr * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [127:0] blk_data(input logic [27:0] blk);
    return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
  endfunction

  // Main memory: garbage while busy, real block once busywait drops.
  assign mem_readdata_i = mem_busywait_i ? ~blk_data(mem_address_o) : blk_data(mem_address_o);

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive memory handshake, let logic settle.
  task automatic begin_cycle();
    mem_busywait_i = mem_read_o && (rd_cnt + 1 < mem_lat);
    #1;
  endtask

  task automatic end_cycle();
    rd_cnt = mem_read_o ? rd_cnt + 1 : 0;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
  endtask

  // Hold an address until the cache delivers it; check stall length, memory
  // traffic and the returned word against the model.
  task automatic fetch(input logic [29:0] a, input int lat, input string nm);
    int          stalls, reads, addr_bad, nop_bad;
    bit          done, exp_hit;
    logic [2:0]  idx;
    logic [31:0] got;
    stalls = 0; reads = 0; addr_bad = 0; nop_bad = 0; done = 1'b0; got = NOP;
    idx     = a[4:2];
    exp_hit = ref_valid[idx] && (ref_tag[idx] == a[29:5]);
    address_i = a; invalidate_i = 1'b0; mem_lat = lat;
    for (int c = 0; c < 64 && !done; c++) begin
      begin_cycle();
      if (mem_read_o === 1'b1) begin
        reads++;
        if (mem_address_o !== a[29:2]) addr_bad++;
      end
      if (blocking_n_o === 1'b1) begin
        done = 1'b1;
        got  = data_o;
      end else begin
        stalls++;
        if (data_o !== NOP) nop_bad++;
      end
      end_cycle();
    end
    chk({nm, " done"},     32'(done),     32'd1);
    chk({nm, " stalls"},   32'(stalls),   exp_hit ? 32'd0 : 32'(lat + 2));
    chk({nm, " reads"},    32'(reads),    exp_hit ? 32'd0 : 32'(lat));
    chk({nm, " mem_addr"}, 32'(addr_bad), 32'd0);
    chk({nm, " nop"},      32'(nop_bad),  32'd0);
    chk({nm, " data"},     got,           mem_word(a[29:2], a[1:0]));
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = a[29:5];
  endtask

  task automatic do_inval(input logic [29:0] a, input string nm);
    address_i = a; invalidate_i = 1'b1; mem_lat = 1;
    begin_cycle();
    chk({nm, " blocking"}, 32'(blocking_n_o), 32'd0);
    chk({nm, " mem_read"}, 32'(mem_read_o),   32'd0);
    chk({nm, " data"},     data_o,            NOP);
    end_cycle();
    invalidate_i = 1'b0;
    clear_model();
  endtask

  initial begin
    seed = $urandom;
    clear_model();

    // Reset state
    #2;
    chk("reset mem_read", 32'(mem_read_o),   32'd0);
    chk("reset blocking", 32'(blocking_n_o), 32'd0);
    chk("reset data",     data_o,            NOP);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    // 1 cold miss, latency 3
    fetch(30'h0000_0000, 3, "cold");
    // 2 sequential hits
    fetch(30'h0000_0001, 3, "seq1");
    fetch(30'h0000_0002, 3, "seq2");
    fetch(30'h0000_0003, 3, "seq3");
    // 3 conflict eviction on index 0
    fetch(30'h0000_0020, 2, "evict");
    fetch(30'h0000_0000, 2, "reload");
    fetch(30'h0000_0001, 2, "reload hit");
    // 4 invalidate
    do_inval(30'h0000_0000, "inval");
    fetch(30'h0000_0000, 2, "post inval");

    // 5 reset during the 2nd MEM_READ cycle
    address_i = 30'h0000_0045; mem_lat = 6;
    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle();
    chk("rst pre mem_read", 32'(mem_read_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rst async mem_read", 32'(mem_read_o),   32'd0);
    chk("rst async blocking", 32'(blocking_n_o), 32'd0);
    @(posedge clk_i); @(negedge clk_i);
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b1; rd_cnt = 0;
    clear_model();
    fetch(30'h0000_0045, 2, "post reset");
    fetch(30'h0000_0000, 2, "post reset cold");

    // 6 zero-latency memory
    fetch(30'h0000_0123, 1, "zero lat");
    fetch(30'h0000_0122, 1, "zero lat hit");

    // Random traffic over a few tags so hits, conflicts and reuse all occur
    for (int n = 0; n < 80; n++) begin
      logic [24:0] t;
      logic [4:0]  lo;
      int          ts;
      ts = $urandom_range(0, 3);
      t  = (ts == 3) ? 25'h1AB_CDEF : 25'(ts);
      lo = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 11) == 0) do_inval({t, lo}, "rnd inval");
      else fetch({t, lo}, $urandom_range(1, 4), "rnd fetch");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
